// File: rtl/ofifo_pkg.sv
// rtl/ofifo_pkg.sv - shared defaults and pointer sizing for the output FIFO array
package ofifo_pkg;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int DEPTH   = 64;

    // One extra MSB beyond the address bits separates full from empty.
    function automatic int ptr_bw(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/ofifo_if.sv
// rtl/ofifo_if.sv - lane write / row read bundle between the MAC array and the SFP stage
interface ofifo_if #(
    parameter int col     = ofifo_pkg::COL,
    parameter int psum_bw = ofifo_pkg::PSUM_BW
);
    logic [psum_bw*col-1:0] in;
    logic [col-1:0]         wr;
    logic                   rd;
    logic [psum_bw*col-1:0] out;
    logic                   o_valid;
    logic                   o_full;
    logic                   o_ready;
    logic                   o_overflow;

    modport master (
        output in, wr, rd,
        input  out, o_valid, o_full, o_ready, o_overflow
    );

    modport slave (
        input  in, wr, rd,
        output out, o_valid, o_full, o_ready, o_overflow
    );
endinterface

// File: rtl/ofifo_lane.sv
// rtl/ofifo_lane.sv - single-lane circular FIFO with MSB-extended pointers
module ofifo_lane
    import ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [psum_bw-1:0] din,
    input  logic               push,
    input  logic               pop,
    output logic [psum_bw-1:0] head,
    output logic               full,
    output logic               empty
);
    localparam int aw = $clog2(depth);
    localparam int pw = ptr_bw(depth);

    logic [psum_bw-1:0] mem [depth];
    logic [pw-1:0]      wr_ptr;
    logic [pw-1:0]      rd_ptr;
    logic               do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);
    assign do_push = push && !full;
    assign head    = mem[rd_ptr[aw-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            // pop is only issued by the top when every lane is non-empty
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[aw-1:0]] <= din;
    end

endmodule

// File: rtl/ofifo_array.sv
// rtl/ofifo_array.sv - re-aligns skewed column lanes into full rows for the SFP stage
module ofifo_array
    import ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = DEPTH
) (
    input  logic  clk,
    input  logic  reset,
    ofifo_if.slave bus
);
    logic [col-1:0]         full_v;
    logic [col-1:0]         empty_v;
    logic [psum_bw*col-1:0] head;
    logic [psum_bw*col-1:0] out_q;
    logic                   ovf_q;
    logic                   valid;
    logic                   rd_acc;

    assign valid  = ~|empty_v;
    assign rd_acc = bus.rd && valid;

    for (genvar i = 0; i < col; i++) begin : g_lane
        ofifo_lane #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .din   (bus.in[psum_bw*i +: psum_bw]),
            .push  (bus.wr[i]),
            .pop   (rd_acc),
            .head  (head[psum_bw*i +: psum_bw]),
            .full  (full_v[i]),
            .empty (empty_v[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (rd_acc) out_q <= head;
            if (|(bus.wr & full_v)) ovf_q <= 1'b1;
        end
    end

    assign bus.out        = out_q;
    assign bus.o_valid    = valid;
    assign bus.o_full     = |full_v;
    assign bus.o_ready    = ~|full_v;
    assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_ofifo_array.sv
// tb/tb_ofifo_array.sv - directed self-checking bench for ofifo_array
module tb_ofifo_array;
    import ofifo_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    ofifo_if #(.col(COL), .psum_bw(PSUM_BW)) bus ();

    ofifo_array #(.col(COL), .psum_bw(PSUM_BW), .depth(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] row_of(input logic [15:0] b);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[16*i +: 16] = b + 16'(i);
        return r;
    endfunction

    task automatic mid_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
    endtask

    logic [127:0] exp_row;

    initial begin
        bus.in = '0;
        bus.wr = '0;
        bus.rd = 1'b0;
        #1;
        check("reset_out", bus.out, 0);
        check("reset_valid", bus.o_valid, 0);
        check("reset_ready", bus.o_ready, 1);
        check("reset_full", bus.o_full, 0);
        check("reset_ovf", bus.o_overflow, 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // aligned row, lane i = i+1
        bus.wr = 8'hFF;
        bus.in = row_of(16'd1);
        tick();
        bus.wr = '0;
        check("aligned_valid", bus.o_valid, 1);
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        check("aligned_out", bus.out, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check("aligned_valid_after", bus.o_valid, 0);

        // rd while empty is ignored
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        check("rd_empty_hold", bus.out, 128'h0008_0007_0006_0005_0004_0003_0002_0001);

        // skewed arrival, one lane per cycle
        bus.in = row_of(16'h0A01);
        for (int i = 0; i < 8; i++) begin
            bus.wr = 8'(1 << i);
            tick();
            check($sformatf("skew_valid_%0d", i), bus.o_valid, (i == 7) ? 1 : 0);
        end
        bus.wr = '0;
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        check("skew_out", bus.out, 128'h0A08_0A07_0A06_0A05_0A04_0A03_0A02_0A01);

        // leave a full row pending, then reset mid-cycle
        bus.wr = 8'hFF;
        tick();
        bus.wr = '0;
        check("pre_reset_valid", bus.o_valid, 1);
        mid_reset();
        check("midrst_out", bus.out, 0);
        check("midrst_valid", bus.o_valid, 0);
        check("midrst_ready", bus.o_ready, 1);
        check("midrst_full", bus.o_full, 0);
        check("midrst_ovf", bus.o_overflow, 0);
        #2 reset = 1'b0;
        tick();
        check("post_reset_valid", bus.o_valid, 0);

        // fill lane 3
        bus.wr = 8'h08;
        for (int k = 0; k < 64; k++) begin
            bus.in = '0;
            bus.in[63:48] = 16'h3000 + 16'(k);
            tick();
        end
        check("fill_full", bus.o_full, 1);
        check("fill_ready", bus.o_ready, 0);
        check("fill_valid", bus.o_valid, 0);
        check("fill_ovf", bus.o_overflow, 0);
        bus.in[63:48] = 16'h3FFF;
        tick();
        check("ovf_set", bus.o_overflow, 1);
        check("ovf_full", bus.o_full, 1);

        // other lanes still accept
        bus.wr = 8'hF7;
        bus.in = row_of(16'h0100);
        tick();
        bus.wr = '0;
        check("others_valid", bus.o_valid, 1);
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        exp_row = row_of(16'h0100);
        exp_row[63:48] = 16'h3000;
        check("fill_out", bus.out, exp_row);
        check("fill_not_full", bus.o_full, 0);

        // refill lane 3 to full, queue two rows on the others
        bus.wr = 8'h08;
        bus.in[63:48] = 16'h3040;
        tick();
        check("refill_full", bus.o_full, 1);
        bus.wr = 8'hF7;
        bus.in = row_of(16'h0200);
        tick(); tick();
        // same-cycle read plus write on the full lane
        bus.wr = 8'h08;
        bus.in[63:48] = 16'hDEAD;
        bus.rd = 1'b1;
        tick();
        bus.wr = '0;
        bus.rd = 1'b0;
        exp_row = row_of(16'h0200);
        exp_row[63:48] = 16'h3001;
        check("rdwr_out", bus.out, exp_row);
        check("rdwr_full", bus.o_full, 0);
        check("rdwr_ovf", bus.o_overflow, 1);
        bus.wr = 8'h08;
        bus.in[63:48] = 16'h3041;
        tick();
        bus.wr = '0;
        check("rdwr_count63", bus.o_full, 1);
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        exp_row[63:48] = 16'h3002;
        check("rdwr_next_head", bus.out, exp_row);

        mid_reset();
        check("rst2_ovf", bus.o_overflow, 0);
        #2 reset = 1'b0;
        tick();

        // streaming across pointer wrap
        bus.wr = 8'hFF;
        bus.in = row_of(16'd0);
        tick();
        check("wrap_valid_0", bus.o_valid, 1);
        for (int c = 1; c < 200; c++) begin
            bus.in = row_of(16'(c * 8));
            bus.rd = 1'b1;
            tick();
            check($sformatf("wrap_out_%0d", c), bus.out, row_of(16'((c - 1) * 8)));
            check($sformatf("wrap_valid_%0d", c), bus.o_valid, 1);
            check($sformatf("wrap_full_%0d", c), bus.o_full, 0);
        end
        bus.wr = '0;
        tick();
        bus.rd = 1'b0;
        check("wrap_last", bus.out, row_of(16'(199 * 8)));
        check("wrap_drained", bus.o_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
